// File: rtl/mem_store_buffer_if.sv
// Store-buffer bus bundle: MEM-stage store/load signals and the DM write port.
//   st_*   : store request from MEM (valid/type/addr/data/pc) and ready/err back
//   ld_*   : same-cycle load probe (valid/addr) and forwarded lanes (be/data) back
//   dm_*   : DM write port (busy in; sel/addr/data/be/pc out)
//   empty, count : occupancy status
// master = MEM stage / memory side, slave = the store buffer.
interface mem_store_buffer_if #(
  parameter int unsigned PTR_W = 2
);
  logic             st_valid;
  logic [1:0]       st_type;
  logic [31:0]      st_addr;
  logic [31:0]      st_data;
  logic [31:0]      st_pc;
  logic             st_ready;
  logic             st_err;
  logic             ld_valid;
  logic [31:0]      ld_addr;
  logic [3:0]       ld_be;
  logic [31:0]      ld_data;
  logic             dm_busy;
  logic             dm_sel;
  logic [31:0]      dm_addr;
  logic [31:0]      dm_data;
  logic [3:0]       dm_be;
  logic [31:0]      dm_pc;
  logic             empty;
  logic [PTR_W:0]   count;

  modport master (
    output st_valid, st_type, st_addr, st_data, st_pc, ld_valid, ld_addr, dm_busy,
    input  st_ready, st_err, ld_be, ld_data, dm_sel, dm_addr, dm_data, dm_be, dm_pc,
           empty, count
  );

  modport slave (
    input  st_valid, st_type, st_addr, st_data, st_pc, ld_valid, ld_addr, dm_busy,
    output st_ready, st_err, ld_be, ld_data, dm_sel, dm_addr, dm_data, dm_be, dm_pc,
           empty, count
  );
endinterface

// File: rtl/mem_store_buffer.sv
// Store buffer between the MEM stage and data memory.
// Queues up to DEPTH lane-aligned stores, drains one per cycle into the DM
// write port when dm_busy is low, and forwards buffered bytes to loads.
// Ports:
//   clk   : clock, all state on posedge
//   reset : synchronous active-low reset
//   bus   : mem_store_buffer_if.slave (store in, load forwarding, DM write out)
module mem_store_buffer #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned PTR_W = 2
) (
  input  logic                clk,
  input  logic                reset,
  mem_store_buffer_if.slave   bus
);

  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [PTR_W:0]   count_q, count_d;
  logic [DEPTH-1:0] valid_q, valid_d;
  logic [29:0]      addr_q [DEPTH];
  logic [29:0]      addr_d [DEPTH];
  logic [31:0]      data_q [DEPTH];
  logic [31:0]      data_d [DEPTH];
  logic [3:0]       be_q   [DEPTH];
  logic [3:0]       be_d   [DEPTH];
  logic [31:0]      pc_q   [DEPTH];
  logic [31:0]      pc_d   [DEPTH];

  logic        aligned;
  logic [3:0]  st_be;
  logic [31:0] st_lane;
  logic        full;
  logic        is_empty;
  logic        push;
  logic        pop;

  // Store decode: byte enables and lane-replicated data.
  always_comb begin
    aligned = 1'b0;
    st_be   = '0;
    st_lane = '0;
    case (bus.st_type)
      2'b00: begin
        aligned = (bus.st_addr[1:0] == 2'b00);
        st_be   = 4'b1111;
        st_lane = bus.st_data;
      end
      2'b01: begin
        aligned = ~bus.st_addr[0];
        st_be   = bus.st_addr[1] ? 4'b1100 : 4'b0011;
        st_lane = {2{bus.st_data[15:0]}};
      end
      2'b10: begin
        aligned = 1'b1;
        st_be   = 4'b0001 << bus.st_addr[1:0];
        st_lane = {4{bus.st_data[7:0]}};
      end
      default: aligned = 1'b0;
    endcase
  end

  assign full     = (count_q == (PTR_W+1)'(DEPTH));
  assign is_empty = (count_q == '0);
  assign push     = bus.st_valid && !full && aligned;
  assign pop      = !is_empty && !bus.dm_busy;

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    valid_d = valid_q;
    addr_d  = addr_q;
    data_d  = data_q;
    be_d    = be_q;
    pc_d    = pc_q;
    if (pop) begin
      head_d          = head_q + PTR_W'(1);
      valid_d[head_q] = 1'b0;
    end
    if (push) begin
      tail_d          = tail_q + PTR_W'(1);
      valid_d[tail_q] = 1'b1;
      addr_d[tail_q]  = bus.st_addr[31:2];
      data_d[tail_q]  = st_lane;
      be_d[tail_q]    = st_be;
      pc_d[tail_q]    = bus.st_pc;
    end
    case ({push, pop})
      2'b10:   count_d = count_q + (PTR_W+1)'(1);
      2'b01:   count_d = count_q - (PTR_W+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      valid_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      valid_q <= valid_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      be_q    <= be_d;
      pc_q    <= pc_d;
    end
  end

  // Forwarding: held entries are contiguous from head, so walking k from the
  // head (oldest) to the tail (youngest) and overwriting lanes leaves each
  // lane holding its youngest matching byte. The head stays visible while
  // it drains because valid_q only clears at the edge.
  logic [PTR_W-1:0] fwd_idx;
  logic [3:0]       fwd_be;
  logic [31:0]      fwd_data;

  always_comb begin
    fwd_idx  = '0;
    fwd_be   = '0;
    fwd_data = '0;
    if (bus.ld_valid) begin
      for (int unsigned k = 0; k < DEPTH; k++) begin
        fwd_idx = head_q + PTR_W'(k);
        if (valid_q[fwd_idx] && (addr_q[fwd_idx] == bus.ld_addr[31:2])) begin
          for (int unsigned b = 0; b < 4; b++) begin
            if (be_q[fwd_idx][b]) begin
              fwd_be[b]          = 1'b1;
              fwd_data[8*b +: 8] = data_q[fwd_idx][8*b +: 8];
            end
          end
        end
      end
    end
  end

  assign bus.st_ready = !full;
  assign bus.st_err   = bus.st_valid && !aligned;
  assign bus.ld_be    = fwd_be;
  assign bus.ld_data  = fwd_data;
  assign bus.dm_sel   = pop;
  assign bus.dm_addr  = is_empty ? '0 : {addr_q[head_q], 2'b00};
  assign bus.dm_data  = is_empty ? '0 : data_q[head_q];
  assign bus.dm_be    = is_empty ? '0 : be_q[head_q];
  assign bus.dm_pc    = is_empty ? '0 : pc_q[head_q];
  assign bus.empty    = is_empty;
  assign bus.count    = count_q;

endmodule
